alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Multi-cycle controller for the 16-bit execute path: accepts one instruction per handshake,
//  decodes it, issues register-file reads, drives the ALUSrc mux select and immediate operand,
//  captures the ALU result and presents a write-back beat. Sits between fetch and regfile/ALU.
// PARAMETERS
//  WIDTH     16  datapath width (instr, operands, result)
//  IMM_W     4   immediate field width (instr[IMM_W-1:0])
//  SEXT_IMM  1   1: sign-extend immediate to WIDTH; 0: zero-extend
// PORTS
//  clk          in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-high
//  instr_valid  in   1      instruction offered
//  instr_ready  out  1      sequencer can accept (high only in IDLE)
//  instr        in   WIDTH  [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt/imm
//  rf_raddr_a   out  4      regfile read addr A (rs)
//  rf_raddr_b   out  4      regfile read addr B (rt)
//  rf_rdata_b   in   WIDTH  regfile data B; sync read, valid 1 cycle after address
//  alu_src_sel  out  1      ALUSrc mux select: 0 = register (rf_rdata_b), 1 = immediate
//  alu_imm      out  WIDTH  extended immediate, drives mux in1
//  alu_op       out  2      00 ADD, 01 SUB, 10 AND, 11 OR
//  alu_result   in   WIDTH  combinational ALU result
//  wb_valid     out  1      write-back beat valid
//  wb_ready     in   1      write-back accepted
//  wb_addr      out  4      destination register (rd)
//  wb_data      out  WIDTH  captured ALU result
//  err_illegal  out  1      one-cycle pulse on illegal opcode
//  busy         out  1      high in any state except IDLE
// BEHAVIOUR
//  Opcodes: 0000-0011 reg form (ADD/SUB/AND/OR, src_sel=0); 0100-0111 imm form (src_sel=1,
//   alu_op=opcode[1:0]); 1xxx illegal.
//  FSM: IDLE -> DECODE -> READ -> EXEC -> WB -> IDLE; all outputs registered.
//   IDLE: instr_ready=1; on instr_valid&&instr_ready latch instr, go DECODE.
//   DECODE: drive rf_raddr_a/b, alu_op, alu_src_sel, alu_imm; illegal -> pulse err_illegal,
//    back to IDLE, no WB beat.
//   READ: wait for sync regfile data; select/op/imm held stable.
//   EXEC: select/op/imm held; alu_result captured into wb_data at end of cycle.
//   WB: wb_valid=1, wb_addr/wb_data stable until wb_ready; on wb_valid&&wb_ready -> IDLE.
//  Latency: handshake edge to wb_valid = 4 cycles; min throughput 1 instr / 5 cycles.
//  alu_src_sel, alu_op, alu_imm valid DECODE..EXEC; alu_src_sel returns to 0 in IDLE.
//  Immediate: imm 0xF -> 0xFFFF (SEXT_IMM=1) or 0x000F (SEXT_IMM=0).
//  Arithmetic wraps mod 2^WIDTH (ALU-side); no overflow flag.
//  instr_valid while busy ignored (instr_ready=0); instr must be held until accepted.
//  wb_ready held low: stay in WB indefinitely, outputs unchanged.
//  Reset (any time, incl. mid-EXEC/WB): state IDLE; instr_ready=1; busy, wb_valid,
//   err_illegal, alu_src_sel=0; alu_op=00; alu_imm, wb_data=0; wb_addr, rf_raddr_*=0;
//   in-flight instruction dropped, no WB beat.
// CONFIGURATION
//  ALU_SEQ_PERF_EN defined: adds output perf_retired[15:0], +1 per WB handshake,
//   wraps 0xFFFF->0x0000, reset 0; illegal ops not counted.
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Shared header alu_seq_defs.vh: opcode constants, ALU_OP encodings, FSM state encodings
//   (3-bit), instr field bit positions.
//  Sub-module alu_seq_decode: combinational opcode -> {legal, alu_op, alu_src_sel} plus
//   immediate extension; sequencer registers its outputs in DECODE.
// TESTING
//  ADD r1=r2+r3, rf_rdata_b=0x0005 -> alu_src_sel=0 in DECODE..EXEC, wb_valid 4 cyc after
//   accept, wb_addr=1, wb_data=alu_result.
//  ADDI r4, imm 0xF, SEXT_IMM=1 -> alu_src_sel=1, alu_imm=0xFFFF, alu_op=00; SEXT_IMM=0
//   -> alu_imm=0x000F.
//  wb_ready low 3 cycles after wb_valid -> wb_valid/addr/data stable, instr_ready=0; accept
//   on 4th cycle, IDLE next cycle.
//  opcode 0x8 -> err_illegal pulse exactly 1 cycle, no wb_valid, back to IDLE.
//  reset asserted mid-EXEC -> all outputs to reset values immediately, next instr completes normally.
//  ALU_SEQ_PERF_EN: 3 legal + 1 illegal instrs -> perf_retired=3; preload near 0xFFFF to check wrap.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the 16-bit execute-path sequencer:
// instruction field positions, opcode classes, ALU encodings, FSM states.
package alu_op_sequencer_pkg;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int RS_HI  = 7;
    localparam int RS_LO  = 4;
    localparam int RT_HI  = 3;
    localparam int RT_LO  = 0;

    // opcode[3:2] selects the instruction class
    localparam logic [1:0] OPC_CLASS_REG = 2'b00;
    localparam logic [1:0] OPC_CLASS_IMM = 2'b01;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_READ   = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic    legal;
        logic    src_sel;
        alu_op_e op;
    } dec_t;

endpackage

// File: rtl/alu_op_sequencer_decode.sv
// Combinational opcode decode and immediate extension.
// The sequencer registers these results on instruction acceptance.
module alu_op_sequencer_decode
    import alu_op_sequencer_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int IMM_W    = 4,
    parameter int SEXT_IMM = 1
)(
    input  logic [3:0]       opcode,
    input  logic [IMM_W-1:0] imm,
    output dec_t             dec,
    output logic [WIDTH-1:0] imm_ext
);

    // Class bits pick operand source; low bits pick the ALU function
    always_comb begin
        dec = '0;
        unique case (opcode[3:2])
            OPC_CLASS_REG: begin
                dec.legal   = 1'b1;
                dec.src_sel = 1'b0;
                dec.op      = alu_op_e'(opcode[1:0]);
            end
            OPC_CLASS_IMM: begin
                dec.legal   = 1'b1;
                dec.src_sel = 1'b1;
                dec.op      = alu_op_e'(opcode[1:0]);
            end
            default: begin
                dec.legal   = 1'b0;
            end
        endcase
    end

    generate
        if (SEXT_IMM != 0) begin : g_sext
            assign imm_ext = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
        end else begin : g_zext
            assign imm_ext = {{(WIDTH-IMM_W){1'b0}}, imm};
        end
    endgenerate

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle execute controller: IDLE->DECODE->READ->EXEC->WB.
// Optional retired-instruction counter enabled by ALU_SEQ_PERF_EN.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int IMM_W    = 4,
    parameter int SEXT_IMM = 1
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [WIDTH-1:0] instr,
    output logic [3:0]       rf_raddr_a,
    output logic [3:0]       rf_raddr_b,
    input  logic [WIDTH-1:0] rf_rdata_b,
    output logic             alu_src_sel,
    output logic [WIDTH-1:0] alu_imm,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [3:0]       wb_addr,
    output logic [WIDTH-1:0] wb_data,
    output logic             err_illegal,
    output logic             busy
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [15:0]      perf_retired
`endif
);

    seq_state_e       state;
    dec_t             dec;
    logic [WIDTH-1:0] dec_imm;
    logic [3:0]       rd_q;
    logic             illegal_q;

    // Operand B reaches the ALU through the external mux, not here
    logic unused_rdata;
    assign unused_rdata = ^rf_rdata_b;

    alu_op_sequencer_decode #(
        .WIDTH    (WIDTH),
        .IMM_W    (IMM_W),
        .SEXT_IMM (SEXT_IMM)
    ) u_decode (
        .opcode  (instr[OPC_HI:OPC_LO]),
        .imm     (instr[IMM_W-1:0]),
        .dec     (dec),
        .imm_ext (dec_imm)
    );

    // Sequencer FSM; every output is a register updated here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            wb_valid    <= 1'b0;
            err_illegal <= 1'b0;
            alu_src_sel <= 1'b0;
            alu_op      <= ALU_ADD;
            alu_imm     <= '0;
            wb_data     <= '0;
            wb_addr     <= '0;
            rf_raddr_a  <= '0;
            rf_raddr_b  <= '0;
            rd_q        <= '0;
            illegal_q   <= 1'b0;
`ifdef ALU_SEQ_PERF_EN
            perf_retired <= '0;
`endif
        end else begin
            err_illegal <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        rd_q        <= instr[RD_HI:RD_LO];
                        rf_raddr_a  <= instr[RS_HI:RS_LO];
                        rf_raddr_b  <= instr[RT_HI:RT_LO];
                        illegal_q   <= !dec.legal;
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_DECODE;
                        if (dec.legal) begin
                            alu_op      <= dec.op;
                            alu_src_sel <= dec.src_sel;
                            alu_imm     <= dec_imm;
                        end else begin
                            err_illegal <= 1'b1;
                        end
                    end
                end
                S_DECODE: begin
                    if (illegal_q) begin
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    wb_data  <= alu_result;
                    wb_addr  <= rd_q;
                    wb_valid <= 1'b1;
                    state    <= S_WB;
                end
                S_WB: begin
                    if (wb_ready) begin
                        wb_valid    <= 1'b0;
                        alu_src_sel <= 1'b0;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
`ifdef ALU_SEQ_PERF_EN
                        perf_retired <= perf_retired + 16'd1;
`endif
                    end
                end
                default: begin
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                    wb_valid    <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule
